// File: rtl/sw_pkg.sv
// sw_pkg: shared definitions for the switch event conditioner.
//   - FSM state encoding (S_RELEASE, S_IDLE, S_VALID)
//   - 2-bit symbol codes for each switch
//   - default debounce length and counter width
//   - helpers to classify and encode a debounced switch vector
package sw_pkg;

   typedef enum logic [1:0] {
      S_RELEASE = 2'd0,
      S_IDLE    = 2'd1,
      S_VALID   = 2'd2
   } state_t;

   localparam logic [1:0] SYM_SW0 = 2'b00;
   localparam logic [1:0] SYM_SW1 = 2'b01;
   localparam logic [1:0] SYM_SW2 = 2'b10;
   localparam logic [1:0] SYM_SW3 = 2'b11;

   // 10 ms at 50 MHz
   localparam int DEBOUNCE_CYCLES_DEF = 500000;
   localparam int CNT_W_DEF           = 20;

   // Highest-index switch wins. For a one-hot vector this is exactly
   // {v[3]|v[2], v[3]|v[1]}.
   function automatic logic [1:0] sym_encode(input logic [3:0] v);
      logic [1:0] s;
      if (v[3])      s = SYM_SW3;
      else if (v[2]) s = SYM_SW2;
      else if (v[1]) s = SYM_SW1;
      else           s = SYM_SW0;
      return s;
   endfunction

   // More than one bit set.
   function automatic logic is_multi(input logic [3:0] v);
      return (v & (v - 4'd1)) != 4'd0;
   endfunction

endpackage

// File: rtl/sw_debounce.sv
// sw_debounce: two-flop synchroniser, stability counter and debounced
// register for a W-bit switch vector.
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   sw       raw switch levels (asynchronous to clk)
//   db       debounced vector, updated after DEBOUNCE_CYCLES stable cycles
//   db_ok    set once the first vector has been accepted since reset
//   level    OR of db, registered together with db
module sw_debounce #(
   parameter int W               = 4,
   parameter int DEBOUNCE_CYCLES = sw_pkg::DEBOUNCE_CYCLES_DEF,
   parameter int CNT_W           = sw_pkg::CNT_W_DEF
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic [W-1:0] sw,
   output logic [W-1:0] db,
   output logic         db_ok,
   output logic         level
);

   logic [W-1:0]     sync1;
   logic [W-1:0]     sync2;
   logic [W-1:0]     sync2_q;
   logic [CNT_W-1:0] cnt;
   logic             stable;
   logic             accept;

   assign stable = (sync2 == sync2_q);
   // The stability qualifier keeps a change that lands on the terminal
   // count from being accepted before it has been observed by the counter.
   assign accept = stable && (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1   <= '0;
         sync2   <= '0;
         sync2_q <= '0;
         cnt     <= '0;
         db      <= '0;
         db_ok   <= 1'b0;
         level   <= 1'b0;
      end else begin
         sync1   <= sw;
         sync2   <= sync1;
         sync2_q <= sync2;
         if (!stable)
            cnt <= '0;
         else if (cnt != {CNT_W{1'b1}})
            cnt <= cnt + CNT_W'(1);
         if (accept) begin
            db    <= sync2;
            level <= |sync2;
            db_ok <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/sw_event_conditioner.sv
// sw_event_conditioner: turns four raw switches into a stream of one
// validated 2-bit symbol per clean press-and-release, with valid/ready.
// Ports:
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   sw[3:0]    raw switch levels
//   sym_ready  downstream accepts sym this cycle
//   sym_valid  sym holds a pending event
//   sym[1:0]   encoded symbol (SW0=00 .. SW3=11)
//   sw_level   OR of the debounced vector
//   err        one-cycle pulse when a multi-switch vector is accepted
// Build option: SW_PRIORITY_RESOLVE_EN resolves multi-switch vectors by
// highest-index priority into a normal event; err then never asserts.
module sw_event_conditioner
   import sw_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int CNT_W           = CNT_W_DEF
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [3:0] sw,
   input  logic       sym_ready,
   output logic       sym_valid,
   output logic [1:0] sym,
   output logic       sw_level,
   output logic       err
);

   logic [3:0] db;
   logic       db_ok;
   state_t     state;

   sw_debounce #(
      .W               (4),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_debounce (
      .clk     (clk),
      .reset_n (reset_n),
      .sw      (sw),
      .db      (db),
      .db_ok   (db_ok),
      .level   (sw_level)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= S_RELEASE;
         sym_valid <= 1'b0;
         sym       <= SYM_SW0;
         err       <= 1'b0;
      end else begin
         err <= 1'b0;
         case (state)
            // db reads 0000 straight out of reset, so only an accepted
            // all-released vector arms the FSM; a switch held through
            // reset therefore has to be released first.
            S_RELEASE: begin
               if (db_ok && db == 4'b0000)
                  state <= S_IDLE;
            end
            S_IDLE: begin
               if (db != 4'b0000) begin
`ifdef SW_PRIORITY_RESOLVE_EN
                  sym       <= sym_encode(db);
                  sym_valid <= 1'b1;
                  state     <= S_VALID;
`else
                  if (is_multi(db)) begin
                     err   <= 1'b1;
                     state <= S_RELEASE;
                  end else begin
                     sym       <= sym_encode(db);
                     sym_valid <= 1'b1;
                     state     <= S_VALID;
                  end
`endif
               end
            end
            // Event held until taken; db activity here is ignored.
            S_VALID: begin
               if (sym_ready) begin
                  sym_valid <= 1'b0;
                  state     <= S_RELEASE;
               end
            end
            default: begin
               sym_valid <= 1'b0;
               state     <= S_RELEASE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sw_event_conditioner.sv
// Testbench for sw_event_conditioner with DEBOUNCE_CYCLES=8.
// A behavioural model built from the debounce and event rules tracks
// every output each cycle; directed scenarios add end-to-end checks.
module tb_sw_event_conditioner;

   localparam int D = 8;
`ifdef SW_PRIORITY_RESOLVE_EN
   localparam bit PRIO = 1'b1;
`else
   localparam bit PRIO = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [3:0] sw = 4'b0000;
   logic       sym_ready = 1'b0;
   logic       sym_valid;
   logic [1:0] sym;
   logic       sw_level;
   logic       err;

   sw_event_conditioner #(
      .DEBOUNCE_CYCLES (D),
      .CNT_W           (20)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .sw        (sw),
      .sym_ready (sym_ready),
      .sym_valid (sym_valid),
      .sym       (sym),
      .sw_level  (sw_level),
      .err       (err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // hist[i] = raw sample taken i clock edges ago; bit 4 marks "no sample"
   // (before reset the synchroniser holds three zero pseudo-samples).
   logic [4:0] hist [0:D+2];
   logic [3:0] m_db;
   logic       m_ok, m_level, m_valid, m_err, m_armed;
   logic [1:0] m_sym;
   logic [3:0] db_old;
   logic       ok_old, stable;

   function automatic logic [1:0] hi_index(input logic [3:0] v);
      logic [1:0] r;
      r = 2'd0;
      for (int i = 0; i < 4; i++) if (v[i]) r = 2'(i);
      return r;
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i <= D + 2; i++) hist[i] = (i <= 2) ? 5'h00 : 5'h10;
         m_db = 4'd0; m_ok = 1'b0; m_level = 1'b0;
         m_valid = 1'b0; m_err = 1'b0; m_armed = 1'b0; m_sym = 2'd0;
      end else begin
         db_old = m_db;
         ok_old = m_ok;
         for (int i = D + 2; i > 0; i--) hist[i] = hist[i-1];
         hist[0] = {1'b0, sw};
         // accepted once the synchronised value has held for D+1 samples
         stable = !hist[2][4];
         for (int i = 3; i <= D + 2; i++) if (hist[i] !== hist[2]) stable = 1'b0;
         m_err = 1'b0;
         if (m_valid) begin
            if (sym_ready) begin m_valid = 1'b0; m_armed = 1'b0; end
         end else if (!m_armed) begin
            if (ok_old && db_old == 4'd0) m_armed = 1'b1;
         end else if (db_old != 4'd0) begin
            if ($countones(db_old) == 1 || PRIO) begin
               m_sym = hi_index(db_old);
               m_valid = 1'b1;
            end else begin
               m_err = 1'b1;
               m_armed = 1'b0;
            end
         end
         if (stable) begin m_db = hist[2][3:0]; m_ok = 1'b1; end
         m_level = |m_db;
      end
   end

   // ---------------- per-cycle comparison and event tallies ----------------
   int ev_total = 0, err_total = 0, lvl_total = 0;
   logic [1:0] last_sym = 2'd0;

   always @(negedge clk) begin
      if (reset_n) begin
         check("sym_valid", 32'(sym_valid), 32'(m_valid));
         if (m_valid) check("sym", 32'(sym), 32'(m_sym));
         check("err", 32'(err), 32'(m_err));
         check("sw_level", 32'(sw_level), 32'(m_level));
         if (sym_valid && sym_ready) begin ev_total++; last_sym = sym; end
         if (err) err_total++;
         if (sw_level) lvl_total++;
      end
   end

   task automatic tick(input int n);
      repeat (n) begin @(posedge clk); #2; end
   endtask

   task automatic wait_valid(input string tag, output int lat);
      lat = 0;
      while (!sym_valid && lat < 40) begin tick(1); lat++; end
      if (!sym_valid) check(tag, 32'(sym_valid), 32'd1);
   endtask

   int e0, r0, l0, lat;
   logic [3:0] pick;

   initial begin
      // reset state
      reset_n = 1'b0; sw = 4'b0000; sym_ready = 1'b0;
      tick(3);
      check("rst_valid", 32'(sym_valid), 32'd0);
      check("rst_sym", 32'(sym), 32'd0);
      check("rst_level", 32'(sw_level), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      reset_n = 1'b1;
      tick(20);

      // single press with ready tied high
      sym_ready = 1'b1; e0 = ev_total; r0 = err_total;
      sw = 4'b0100;
      wait_valid("press_timeout", lat);
      check("press_latency_in_window", 32'(lat >= 10 && lat <= 12), 32'd1);
      tick(5);
      check("press_events", 32'(ev_total - e0), 32'd1);
      check("press_sym", 32'(last_sym), 32'd2);
      check("press_err", 32'(err_total - r0), 32'd0);
      sw = 4'b0000; tick(30);
      check("release_no_event", 32'(ev_total - e0), 32'd1);

      // backpressure
      sym_ready = 1'b0; sw = 4'b0010;
      wait_valid("bp_timeout", lat);
      tick(20);
      check("bp_held_valid", 32'(sym_valid), 32'd1);
      check("bp_held_sym", 32'(sym), 32'd1);
      sym_ready = 1'b1; tick(1);
      check("bp_drop", 32'(sym_valid), 32'd0);
      sw = 4'b0000; tick(30);

      // bounce shorter than the debounce window
      e0 = ev_total; l0 = lvl_total;
      for (int i = 0; i < 20; i++) begin sw = (i % 2) ? 4'b1000 : 4'b0000; tick(5); end
      sw = 4'b0000; tick(15);
      check("bounce_events", 32'(ev_total - e0), 32'd0);
      check("bounce_level", 32'(lvl_total - l0), 32'd0);

      // two switches together
      e0 = ev_total; r0 = err_total;
      sw = 4'b0011; tick(30);
      check("multi_err", 32'(err_total - r0), PRIO ? 32'd0 : 32'd1);
      check("multi_events", 32'(ev_total - e0), PRIO ? 32'd1 : 32'd0);
      if (PRIO) check("multi_sym", 32'(last_sym), 32'd1);
      sw = 4'b0000; tick(30);

      // held through reset
      reset_n = 1'b0; sw = 4'b0001; tick(3);
      reset_n = 1'b1; e0 = ev_total;
      tick(40);
      check("held_no_event", 32'(ev_total - e0), 32'd0);
      sw = 4'b0000; tick(30);
      sw = 4'b0001; tick(30);
      check("repress_events", 32'(ev_total - e0), 32'd1);
      check("repress_sym", 32'(last_sym), 32'd0);
      sw = 4'b0000; tick(30);

      // asynchronous reset during a pending event
      sym_ready = 1'b0; sw = 4'b0100;
      wait_valid("rst_mid_timeout", lat);
      tick(3); #1;
      reset_n = 1'b0; #1;
      check("async_valid", 32'(sym_valid), 32'd0);
      check("async_sym", 32'(sym), 32'd0);
      check("async_level", 32'(sw_level), 32'd0);
      tick(3);
      reset_n = 1'b1; e0 = ev_total; sym_ready = 1'b1;
      tick(40);
      check("no_stale_event", 32'(ev_total - e0), 32'd0);
      check("no_stale_valid", 32'(sym_valid), 32'd0);
      sw = 4'b0000; tick(30);

      // randomized press/hold/release with random backpressure
      for (int seg = 0; seg < 80; seg++) begin
         case ($urandom_range(0, 3))
            0: pick = 4'b0000;
            1, 2: pick = 4'b0001 << $urandom_range(0, 3);
            default: pick = 4'($urandom_range(0, 15));
         endcase
         sw = pick;
         if ($urandom_range(0, 24) == 0) begin
            #1 reset_n = 1'b0; tick(2); reset_n = 1'b1;
         end
         repeat ($urandom_range(1, 30)) begin
            sym_ready = ($urandom_range(0, 2) != 0);
            tick(1);
         end
      end
      sw = 4'b0000; sym_ready = 1'b1; tick(30);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
